// File: rtl/can_bit_sync_engine.sv
// rtl/can_bit_sync_engine.sv - CAN bit timing, hard sync and SJW-limited resynchronization engine
module can_bit_sync_engine #(
  parameter int BRP_W   = 8,
  parameter int TSEG1_W = 6,
  parameter int TSEG2_W = 5,
  parameter int SJW_W   = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [BRP_W-1:0]          brp,
  input  logic [TSEG1_W-1:0]        tseg1,
  input  logic [TSEG2_W-1:0]        tseg2,
  input  logic [SJW_W-1:0]          sjw,
  input  logic                      hard_sync_enable,
  input  logic                      both_edges_mode,
  input  logic                      triple_sample_mode,
  input  logic                      rx,
  output logic                      tq_tick,
  output logic [1:0]                segment,
  output logic                      sample_point,
  output logic                      sampled_bit,
  output logic                      bit_end,
  output logic                      hard_sync_applied,
  output logic                      resync_applied,
  output logic signed [TSEG1_W+1:0] phase_error,
  output logic [SJW_W-1:0]          resync_amount,
  output logic                      sync_error,
  output logic                      config_error
);

  // Counter width holds a full bit (1 + tseg1 + ext + tseg2) and the signed phase error.
  localparam int CNT_W = TSEG1_W + 2;

  localparam logic [1:0] SEG_SYNC  = 2'd0;
  localparam logic [1:0] SEG_TSEG1 = 2'd1;
  localparam logic [1:0] SEG_TSEG2 = 2'd2;

  logic [BRP_W-1:0] prescaler;
  logic [CNT_W-1:0] tq_cnt;
  logic [SJW_W-1:0] ext;
  logic [SJW_W-1:0] shr;
  logic             sync_used;
  logic             rx_prev;
  logic [1:0]       tri_hist;

  logic             cfg_bad;
  logic             run;
  logic [CNT_W-1:0] tseg1_x, tseg2_x, ext_x, shr_x, sjw_x;
  logic [CNT_W-1:0] seg1_end, bit_last, end_lim, early_dist;
  logic             in_sync, in_tseg1, in_tseg2;
  logic             bus_edge, hard_now, resync_ok, early_now, nominal_end;
  logic [SJW_W-1:0] late_amt;
  logic             majority;

  assign cfg_bad = (tseg1 < TSEG1_W'(2)) || (tseg2 == '0) || (sjw == '0) ||
                   (CNT_W'(sjw) > CNT_W'(tseg1)) || (CNT_W'(sjw) > CNT_W'(tseg2)) ||
                   (triple_sample_mode && (tseg1 < TSEG1_W'(3)));
  // Pulses must stay quiet while the async reset is active, so reset_n gates run too.
  assign run          = reset_n && enable && !cfg_bad;
  assign config_error = reset_n && enable && cfg_bad;

  assign tseg1_x    = CNT_W'(tseg1);
  assign tseg2_x    = CNT_W'(tseg2);
  assign ext_x      = CNT_W'(ext);
  assign shr_x      = CNT_W'(shr);
  assign sjw_x      = CNT_W'(sjw);
  assign seg1_end   = tseg1_x + ext_x;
  assign bit_last   = seg1_end + tseg2_x;
  assign end_lim    = bit_last - shr_x;
  // Distance from an edge in TSEG2 to the next nominal SYNC_SEG, i.e. |phase error|.
  assign early_dist = bit_last + CNT_W'(1) - tq_cnt;

  assign in_sync  = (tq_cnt == '0);
  assign in_tseg1 = !in_sync && (tq_cnt <= seg1_end);
  assign in_tseg2 = !in_sync && !in_tseg1;
  assign segment  = in_sync ? SEG_SYNC : (in_tseg1 ? SEG_TSEG1 : SEG_TSEG2);

  assign bus_edge  = run && (both_edges_mode ? (rx_prev != rx) : (rx_prev && !rx));
  assign hard_now  = bus_edge && hard_sync_enable;
  assign resync_ok = bus_edge && !hard_sync_enable && !sync_used;
  assign early_now = resync_ok && in_tseg2 && (early_dist <= sjw_x);
  assign late_amt  = (tq_cnt < sjw_x) ? SJW_W'(tq_cnt) : sjw;

  assign tq_tick      = run && (prescaler == brp);
  assign sample_point = tq_tick && (tq_cnt == seg1_end);
  assign nominal_end  = tq_tick && (tq_cnt >= end_lim);
  assign bit_end      = nominal_end || early_now;

  // Two earlier tq-tick samples plus the current rx form the triple-sample vote.
  assign majority = (tri_hist[1] & tri_hist[0]) | (tri_hist[1] & rx) | (tri_hist[0] & rx);

  // Previous bus level for edge detection; tracks rx even while the engine is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_prev <= 1'b1;
    else          rx_prev <= rx;
  end

  // Bit timing state: prescaler, tq position, sync corrections and sampled value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler         <= '0;
      tq_cnt            <= '0;
      ext               <= '0;
      shr               <= '0;
      sync_used         <= 1'b0;
      tri_hist          <= 2'b11;
      sampled_bit       <= 1'b1;
      hard_sync_applied <= 1'b0;
      resync_applied    <= 1'b0;
      sync_error        <= 1'b0;
      phase_error       <= '0;
      resync_amount     <= '0;
    end else if (!run) begin
      prescaler         <= '0;
      tq_cnt            <= '0;
      ext               <= '0;
      shr               <= '0;
      sync_used         <= 1'b0;
      tri_hist          <= 2'b11;
      sampled_bit       <= 1'b1;
      hard_sync_applied <= 1'b0;
      resync_applied    <= 1'b0;
      sync_error        <= 1'b0;
      phase_error       <= '0;
      resync_amount     <= '0;
    end else begin
      hard_sync_applied <= 1'b0;
      resync_applied    <= 1'b0;
      sync_error        <= 1'b0;
      prescaler         <= tq_tick ? '0 : prescaler + BRP_W'(1);
      if (tq_tick) begin
        tri_hist <= {tri_hist[0], rx};
        if (nominal_end) begin
          tq_cnt <= '0;
          ext    <= '0;
          shr    <= '0;
        end else begin
          tq_cnt <= tq_cnt + CNT_W'(1);
        end
      end
      if (sample_point) begin
        sampled_bit <= triple_sample_mode ? majority : rx;
        sync_used   <= 1'b0;
      end
      // Sync actions come last so they override the bit-end restart and sync_used clear.
      if (hard_now) begin
        prescaler         <= '0;
        tq_cnt            <= '0;
        ext               <= '0;
        shr               <= '0;
        sync_used         <= 1'b1;
        hard_sync_applied <= 1'b1;
        phase_error       <= '0;
      end else if (bus_edge && !hard_sync_enable && sync_used) begin
        sync_error <= 1'b1;
      end else if (resync_ok && in_tseg1) begin
        ext            <= late_amt;
        phase_error    <= $signed(tq_cnt);
        resync_amount  <= late_amt;
        resync_applied <= 1'b1;
        sync_used      <= 1'b1;
      end else if (resync_ok && in_tseg2) begin
        phase_error    <= $signed(CNT_W'(0) - early_dist);
        resync_applied <= 1'b1;
        sync_used      <= 1'b1;
        if (early_dist <= sjw_x) begin
          // Edge tq becomes the new SYNC_SEG; the prescaler keeps running.
          tq_cnt        <= '0;
          ext           <= '0;
          shr           <= '0;
          resync_amount <= SJW_W'(early_dist);
        end else begin
          shr           <= sjw;
          resync_amount <= sjw;
        end
      end
    end
  end

endmodule

// File: doc/can_bit_sync_engine.md
Name: can_bit_sync_engine

Overview:
- Parametrised CAN bit-timing and synchronization engine.
- Generates time quanta from a baud prescaler and tracks SYNC_SEG / TSEG1 / TSEG2 inside each bit.
- Detects bus edges, computes phase error and applies hard sync or SJW-limited resynchronization. Produces the sample point, the sampled bit and the bit-end strobe.
- Sits between the RX input synchronizer and the bit stream processor.

Parameters:
- BRP_W, 8, width of baud prescaler value
- TSEG1_W, 6, width of tseg1 (PROP+PHASE1) length in tq; TSEG1_W >= TSEG2_W
- TSEG2_W, 5, width of tseg2 (PHASE2) length in tq
- SJW_W, 4, width of synchronization jump width

Ports:
- clock  in  1  system clock
- reset_n  in  1  async active-low reset
- enable  in  1  engine run; low = held in reset state
- brp  in  BRP_W  clocks per tq minus 1
- tseg1  in  TSEG1_W  TSEG1 length in tq (valid 2..max)
- tseg2  in  TSEG2_W  TSEG2 length in tq (valid 1..max)
- sjw  in  SJW_W  jump width in tq (valid 1..min(tseg1,tseg2))
- hard_sync_enable  in  1  bus idle / SOF window: edges cause hard sync
- both_edges_mode  in  1  1 = resync on both edge polarities, 0 = recessive-to-dominant only
- triple_sample_mode  in  1  1 = majority of 3 samples
- rx  in  1  synchronized bus level (1 = recessive)
- tq_tick  out  1  pulse on last clock of each tq
- segment  out  2  0 SYNC_SEG, 1 TSEG1, 2 TSEG2
- sample_point  out  1  pulse at end of TSEG1
- sampled_bit  out  1  registered sampled bus value
- bit_end  out  1  pulse on last clock of bit
- hard_sync_applied  out  1  pulse
- resync_applied  out  1  pulse
- phase_error  out  TSEG1_W+2  signed tq error of last sync edge
- resync_amount  out  SJW_W  applied correction magnitude
- sync_error  out  1  pulse: edge ignored (sync already used)
- config_error  out  1  level: invalid tseg1/tseg2/sjw

Behaviour:
- Reset and !enable: prescaler=0, tq_cnt=0, ext=0, sync_used=0, segment=0, sampled_bit=1. All pulses, phase_error, resync_amount and config_error are 0. Reset mid-bit restarts at SYNC_SEG.
- config_error is asserted when tseg1<2, tseg2<1, sjw==0, sjw>tseg1, sjw>tseg2, or triple_sample_mode && tseg1<3. While asserted, the engine is held as in reset except config_error itself.
- Prescaler counts 0..brp. tq_tick is asserted when count==brp. brp=0 gives one clock per tq.
- tq_cnt advances on tq_tick.
  - tq 0 = SYNC_SEG.
  - 1..tseg1+ext = TSEG1.
  - Following tq up to end_lim = tseg1+ext+tseg2-shr = TSEG2.
- sample_point and bit_end are combinational from registered state and qualified by tq_tick.
  - sample_point: tq_cnt==tseg1+ext.
  - bit_end: tq_cnt>=end_lim. At bit_end, tq_cnt<=0 and ext<=0, shr<=0.
- sampled_bit is updated at sample_point (visible next clock). In triple_sample_mode it is the majority of rx captured at the last 3 tq ticks of TSEG1.
- Edge: rx_prev==1 && rx==0, or rx_prev!=rx if both_edges_mode. rx_prev is the previous clock's rx.
- Hard sync: edge && hard_sync_enable.
  - prescaler<=0, tq_cnt<=0, ext<=0, shr<=0, sync_used<=1.
  - hard_sync_applied pulse; phase_error<=0.
  - Takes priority over resync and ignores sync_used.
- Resync: edge && !hard_sync_enable && !sync_used. Phase error e:
  - Edge in SYNC_SEG: e=0, no action, no flag set.
  - Edge in TSEG1: e=+tq_cnt. ext<=min(e,sjw).
  - Edge in TSEG2: e=tq_cnt-(1+tseg1+ext+tseg2) (negative).
    - If |e|<=sjw: tq_cnt<=0 immediately (edge tq becomes SYNC_SEG; prescaler not reset) and bit_end pulses.
    - Else: shr<=sjw.
  - On any nonzero-e resync: resync_applied pulse, phase_error<=e, resync_amount<=applied magnitude, sync_used<=1.
- sync_used is cleared at sample_point. An edge with sync_used=1 (not hard sync) is ignored and pulses sync_error.
- Simultaneous events:
  - Edge on the same clock as sample_point: sync is evaluated first with the current tq_cnt; sync_used is then set, not cleared.
  - Edge on a bit_end clock: hard sync or resync state wins over the bit-end restart.

Test Plan:
- Nominal timing: brp=1, tseg1=5, tseg2=4, sjw=2, rx=1 -> tq_tick every 2 clocks; sample_point on the 6th tq_tick after enable (clock 12), bit_end on the 10th (clock 20), then a 20-clock period.
- Hard sync: hard_sync_enable=1, rx 1->0 at tq_cnt 7 -> hard_sync_applied, segment=0 next clock, sample_point exactly 12 clocks after the edge clock.
- Late edge: rx 1->0 at tq_cnt 3 -> phase_error=+3, resync_amount=2, sample_point at tq 7, bit length 12 tq.
- Early edges:
  - Edge at tq_cnt 8 -> e=-2 <= sjw; bit_end on that clock; tq_cnt=0.
  - Edge at tq_cnt 6 -> e=-4, resync_amount=2; bit ends after tq 7 (8 tq).
- Second edge in same bit (before sample_point) -> sync_error pulse, timing unchanged.
- Two sub-cases:
  - both_edges_mode=0 with 0->1 edge -> no sync.
  - triple_sample_mode with rx pattern 0,1,0 across the last 3 TSEG1 ticks -> sampled_bit=0.
- sjw=6 with tseg2=4 -> config_error=1, no tq_tick. Deassert reset mid-bit -> restart at tq 0.
